// File: rtl/mini_alu_core.sv
// Two-stage register-register ALU: stage 1 latches the decoded instruction and its operands,
// stage 2 executes, writes the register file and presents the result.
module mini_alu_core #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic [31:0]           i_instr,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data1,
    output logic                  o_valid1
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_t;

    logic [DATA_WIDTH-1:0] r_rf [32];
    logic                  r_s1_valid;
    op_t                   r_s1_op;
    logic [4:0]            r_s1_dest;
    logic [DATA_WIDTH-1:0] r_s1_a;
    logic [DATA_WIDTH-1:0] r_s1_b;

    logic                  w_accept;
    logic                  w_fwd_en;
    op_t                   w_op;
    logic [4:0]            w_dest;
    logic [4:0]            w_src1;
    logic [4:0]            w_src2;
    logic [DATA_WIDTH-1:0] w_result;
    logic [DATA_WIDTH-1:0] w_opa;
    logic [DATA_WIDTH-1:0] w_opb;
    logic                  w_unused;

    // The core never stalls, so readiness only depends on reset.
    assign o_ready  = ~i_RST;
    assign w_accept = i_valid & o_ready;
    assign w_op     = op_t'(i_instr[31:30]);
    assign w_dest   = i_instr[29:25];
    assign w_src1   = i_instr[24:20];
    assign w_src2   = i_instr[19:15];
    assign w_unused = ^i_instr[14:0];

    // Stage-2 execute.
    always_comb begin
        w_result = '0;
        case (r_s1_op)
            OP_ADD:  w_result = r_s1_a + r_s1_b;
            OP_SUB:  w_result = r_s1_a - r_s1_b;
            OP_AND:  w_result = r_s1_a & r_s1_b;
            OP_OR:   w_result = r_s1_a | r_s1_b;
            default: w_result = '0;
        endcase
    end

    // Operand read with forwarding of the result being written back on the same edge.
    always_comb begin
        w_fwd_en = r_s1_valid && (r_s1_dest != 5'd0);
        w_opa    = '0;
        w_opb    = '0;
        if (w_fwd_en && (r_s1_dest == w_src1)) begin
            w_opa = w_result;
        end else begin
            w_opa = r_rf[w_src1];
        end
        if (w_fwd_en && (r_s1_dest == w_src2)) begin
            w_opb = w_result;
        end else begin
            w_opb = r_rf[w_src2];
        end
    end

    // Pipeline registers and result output.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= OP_ADD;
            r_s1_dest  <= 5'd0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            o_valid1   <= 1'b0;
            o_data1    <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_op   <= w_op;
                r_s1_dest <= w_dest;
                r_s1_a    <= w_opa;
                r_s1_b    <= w_opb;
            end
            o_valid1 <= r_s1_valid;
            if (r_s1_valid) begin
                o_data1 <= w_result;
            end
        end
    end

    // Register file; R0 is never written so it always reads zero.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            for (int i = 0; i < 32; i++) begin
                if (i == 1) begin
                    r_rf[i] <= DATA_WIDTH'(32'd5);
                end else if (i == 2) begin
                    r_rf[i] <= DATA_WIDTH'(32'd10);
                end else begin
                    r_rf[i] <= '0;
                end
            end
        end else if (r_s1_valid && (r_s1_dest != 5'd0)) begin
            r_rf[r_s1_dest] <= w_result;
        end
    end

endmodule

// File: tb/tb_mini_alu_core.sv
// Self-checking bench for mini_alu_core: directed and random instructions checked
// against an architectural (in-order, sequential) register-file model.
module tb_mini_alu_core;

    logic        i_CLK = 1'b0;
    logic        i_RST;
    logic [31:0] i_instr;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  o_data1;
    logic        o_valid1;

    typedef struct {
        int         due;
        logic [7:0] data;
    } exp_t;

    exp_t       q[$];
    logic [7:0] ref_rf [32];
    logic [7:0] hold;
    int         t;
    int         compared;
    int         mism;

    mini_alu_core #(.DATA_WIDTH(8)) dut (
        .i_CLK   (i_CLK),
        .i_RST   (i_RST),
        .i_instr (i_instr),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data1 (o_data1),
        .o_valid1(o_valid1)
    );

    always #5 i_CLK = ~i_CLK;

    function automatic logic [31:0] mk(input logic [1:0] op, input logic [4:0] d,
                                       input logic [4:0] s1, input logic [4:0] s2);
        logic [31:0] junk;
        junk = $urandom;
        mk = {op, d, s1, s2, junk[14:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s step %0d: observed %0d expected %0d", tag, t, obs, exp);
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 32; i++) ref_rf[i] = 8'd0;
        ref_rf[1] = 8'd5;
        ref_rf[2] = 8'd10;
    endtask

    // One clock: check outputs at the falling edge, then drive the next inputs.
    task automatic step(input logic v, input logic [31:0] ins, input logic rst);
        logic       exp_v;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        int         d;
        @(negedge i_CLK);
        t++;
        exp_v = (q.size() > 0) && (q[0].due == t);
        chk("ready", {31'd0, o_ready}, {31'd0, ~i_RST});
        chk("valid", {31'd0, o_valid1}, {31'd0, exp_v});
        if (exp_v) begin
            chk("data", {24'd0, o_data1}, {24'd0, q[0].data});
            hold = q[0].data;
            void'(q.pop_front());
        end else begin
            chk("hold", {24'd0, o_data1}, {24'd0, hold});
        end
        i_RST   = rst;
        i_valid = v;
        i_instr = ins;
        if (rst) begin
            q.delete();
            hold = 8'd0;
            ref_reset();
        end else if (v) begin
            a = ref_rf[ins[24:20]];
            b = ref_rf[ins[19:15]];
            case (ins[31:30])
                2'b00:   res = a + b;
                2'b01:   res = a - b;
                2'b10:   res = a & b;
                default: res = a | b;
            endcase
            d = int'(ins[29:25]);
            if (d != 0) ref_rf[d] = res;
            q.push_back('{due: t + 2, data: res});
        end
    endtask

    initial begin
        logic        rv;
        logic        rr;
        logic [31:0] ri;
        i_RST = 1'b1;
        i_valid = 1'b0;
        i_instr = 32'd0;
        t = 0;
        compared = 0;
        mism = 0;
        hold = 8'd0;
        ref_reset();

        // Reset held, with a valid pulse that must be ignored.
        step(1'b0, 32'd0, 1'b1);
        step(1'b1, mk(2'b00, 5'd3, 5'd1, 5'd2), 1'b1);
        step(1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b0);

        // Basic ops, back-to-back with bypass.
        step(1'b1, mk(2'b00, 5'd3, 5'd1, 5'd2), 1'b0);   // 15
        step(1'b1, mk(2'b01, 5'd4, 5'd3, 5'd1), 1'b0);   // 10 via bypass
        step(1'b1, mk(2'b10, 5'd5, 5'd1, 5'd2), 1'b0);   // 0
        step(1'b1, mk(2'b11, 5'd6, 5'd1, 5'd2), 1'b0);   // 15
        step(1'b1, mk(2'b01, 5'd7, 5'd1, 5'd2), 1'b0);   // 251
        for (int i = 0; i < 5; i++) step(1'b1, mk(2'b00, 5'd3, 5'd3, 5'd3), 1'b0);
        step(1'b0, 32'd0, 1'b0);

        // R0 destination is reported but discarded.
        step(1'b1, mk(2'b00, 5'd0, 5'd1, 5'd2), 1'b0);   // 15
        step(1'b1, mk(2'b00, 5'd8, 5'd0, 5'd1), 1'b0);   // 5
        step(1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b0);

        // Reset while an instruction sits in stage 1.
        step(1'b1, mk(2'b00, 5'd9, 5'd1, 5'd2), 1'b0);
        step(1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b0);
        step(1'b1, mk(2'b00, 5'd10, 5'd9, 5'd0), 1'b0);  // 0: write dropped
        step(1'b1, mk(2'b00, 5'd11, 5'd1, 5'd0), 1'b0);  // 5
        step(1'b1, mk(2'b00, 5'd12, 5'd2, 5'd0), 1'b0);  // 10
        step(1'b1, mk(2'b00, 5'd13, 5'd3, 5'd0), 1'b0);  // 0: R3 reloaded
        step(1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b0);

        // Random traffic on a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 79) == 0);
            ri = mk(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            step(rv, ri, rr);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b0);
        chk("drain", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
